// File: rtl/switch_mcu_ifu_prefetch.sv
// Instruction-fetch unit with prefetch FIFO for the switch MCU core.
//
// Issues pipelined incrementing word reads on AHB-Lite, buffers returned
// words with their PC (and a bus-error flag) in a FIFO, and hands them to
// the decoder over valid/ready. Handles PC redirects and bus errors.
//
// Ports:
//   in_clk, in_rst        clock, asynchronous active-high reset
//   in_init_done          start fetching once seen high (sticky)
//   in_hready/in_hresp/in_hrdata   AHB slave response
//   out_haddr/out_htrans  AHB address phase; other out_h* are constant
//   out_inst_valid/out_inst/out_inst_pc/out_inst_err, in_inst_ready
//                         FIFO head towards the decoder
//   in_pc_override/in_pc_write    single-cycle redirect request and target
//   out_fifo_level        current FIFO occupancy
module switch_mcu_ifu_prefetch #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_init_done,
    input  logic             in_hready,
    input  logic             in_hresp,
    input  logic [31:0]      in_hrdata,
    output logic [31:0]      out_haddr,
    output logic [1:0]       out_htrans,
    output logic             out_hwrite,
    output logic [2:0]       out_hsize,
    output logic [2:0]       out_hburst,
    output logic [3:0]       out_hprot,
    output logic             out_hmastlock,
    output logic             out_inst_valid,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_inst_pc,
    output logic             out_inst_err,
    input  logic             in_inst_ready,
    input  logic             in_pc_override,
    input  logic [31:0]      in_pc_write,
    output logic [LVL_W-1:0] out_fifo_level
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StWaitInit, StFetch, StHalt} state_e;
    state_e state_q, state_d;

    logic [31:0]      haddr_q, haddr_d;
    logic             seq_q, seq_d;
    logic             held_q, held_d;
    logic             redir_pend_q, redir_pend_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic             dphase_q, dphase_d;
    logic [31:0]      dpc_q, dpc_d;
    logic             discard_q, discard_d;
    logic             err_q, err_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

    logic [31:0]           mem_inst_q [FIFO_DEPTH];
    logic [31:0]           mem_pc_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_err_q;

    logic [31:0] redir_target;
    logic        credit_ok, addr_active, held_now, accept;
    logic        complete, push, push_err, pop, fifo_valid;

    assign redir_target = {in_pc_write[31:2], 2'b00};
    // Reserve a slot for the data phase already on the bus.
    assign credit_ok    = (32'(count_q) + 32'(dphase_q)) < FIFO_DEPTH;
    assign accept       = addr_active && in_hready;
    assign held_now     = addr_active && !in_hready;
    assign complete     = dphase_q && in_hready;
    // A redirect in the same cycle drops the returning word.
    assign push         = complete && !discard_q && !in_pc_override;
    assign push_err     = push && in_hresp;
    assign fifo_valid   = (count_q != '0);
    assign pop          = fifo_valid && in_inst_ready && !in_pc_override;

    // FSM state register
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) state_q <= StWaitInit;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitInit: if (in_init_done)   state_d = StFetch;
            StFetch:    if (push_err)       state_d = StHalt;
            StHalt:     if (in_pc_override) state_d = StFetch;
            default:                        state_d = StWaitInit;
        endcase
    end

    // FSM outputs: a transfer stalled by hready=0 stays on the bus regardless of credit.
    always_comb begin
        addr_active = (state_q == StFetch) && !err_q && (held_q || credit_ok);
        out_htrans  = addr_active ? (seq_q ? 2'b11 : 2'b10) : 2'b00;
        out_haddr   = haddr_q;
    end

    // Address sequencing and data-phase tracking
    always_comb begin
        haddr_d      = haddr_q;
        seq_d        = seq_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        held_d       = held_now;
        if (in_pc_override && !held_now) begin
            haddr_d      = redir_target;
            seq_d        = 1'b0;
            redir_pend_d = 1'b0;
        end else if (in_pc_override) begin
            // Stalled address phase must be held; retarget once it is accepted.
            redir_pend_d = 1'b1;
            redir_pc_d   = redir_target;
        end else if (accept) begin
            if (redir_pend_q) begin
                haddr_d      = redir_pc_q;
                seq_d        = 1'b0;
                redir_pend_d = 1'b0;
            end else begin
                haddr_d = haddr_q + 32'd4;
                seq_d   = 1'b1;
            end
        end else if (!addr_active) begin
            seq_d = 1'b0;
        end

        if (in_hready) begin
            dphase_d  = accept;
            dpc_d     = haddr_q;
            // A transfer accepted alongside or before a pending redirect is stale.
            discard_d = accept && (in_pc_override || redir_pend_q);
            err_d     = 1'b0;
        end else begin
            dphase_d  = dphase_q;
            dpc_d     = dpc_q;
            discard_d = discard_q || (in_pc_override && dphase_q);
            // First error cycle: go IDLE from the next cycle on.
            err_d     = err_q || (dphase_q && in_hresp);
        end
    end

    // FIFO pointers and level; a redirect flush beats push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (in_pc_override) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            haddr_q      <= RESET_PC;
            seq_q        <= 1'b0;
            held_q       <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            dphase_q     <= 1'b0;
            dpc_q        <= '0;
            discard_q    <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            haddr_q      <= haddr_d;
            seq_q        <= seq_d;
            held_q       <= held_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            dphase_q     <= dphase_d;
            dpc_q        <= dpc_d;
            discard_q    <= discard_d;
            err_q        <= err_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge in_clk) begin
        if (push) begin
            mem_inst_q[wr_ptr_q] <= push_err ? 32'h0 : in_hrdata;
            mem_pc_q[wr_ptr_q]   <= dpc_q;
            mem_err_q[wr_ptr_q]  <= in_hresp;
        end
    end

    assign out_inst_valid = fifo_valid;
    assign out_inst       = fifo_valid ? mem_inst_q[rd_ptr_q] : 32'h0;
    assign out_inst_pc    = fifo_valid ? mem_pc_q[rd_ptr_q] : 32'h0;
    assign out_inst_err   = fifo_valid && mem_err_q[rd_ptr_q];
    assign out_fifo_level = count_q;

    assign out_hwrite    = 1'b0;
    assign out_hsize     = 3'b010;
    assign out_hburst    = 3'b001;
    assign out_hprot     = 4'b0010;
    assign out_hmastlock = 1'b0;
endmodule

// File: tb/tb_switch_mcu_ifu_prefetch.sv
// Directed bench for switch_mcu_ifu_prefetch (FIFO_DEPTH=4, RESET_PC=0x100).
// A small AHB slave model returns the transfer address as read data.
module tb_switch_mcu_ifu_prefetch;
    logic        in_clk = 1'b0;
    logic        in_rst, in_init_done, in_hready, in_hresp;
    logic        in_inst_ready, in_pc_override;
    logic [31:0] in_hrdata, in_pc_write;
    logic [31:0] out_haddr, out_inst, out_inst_pc;
    logic [1:0]  out_htrans;
    logic        out_hwrite, out_hmastlock, out_inst_valid, out_inst_err;
    logic [2:0]  out_hsize, out_hburst;
    logic [3:0]  out_hprot;
    logic [2:0]  out_fifo_level;
    logic [31:0] slave_addr;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

    switch_mcu_ifu_prefetch #(
        .FIFO_DEPTH(4),
        .RESET_PC  (32'h0000_0100)
    ) dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_init_done  (in_init_done),
        .in_hready     (in_hready),
        .in_hresp      (in_hresp),
        .in_hrdata     (in_hrdata),
        .out_haddr     (out_haddr),
        .out_htrans    (out_htrans),
        .out_hwrite    (out_hwrite),
        .out_hsize     (out_hsize),
        .out_hburst    (out_hburst),
        .out_hprot     (out_hprot),
        .out_hmastlock (out_hmastlock),
        .out_inst_valid(out_inst_valid),
        .out_inst      (out_inst),
        .out_inst_pc   (out_inst_pc),
        .out_inst_err  (out_inst_err),
        .in_inst_ready (in_inst_ready),
        .in_pc_override(in_pc_override),
        .in_pc_write   (in_pc_write),
        .out_fifo_level(out_fifo_level)
    );

    always #5 in_clk = ~in_clk;

    // Slave: latch the accepted address, return it as data in the data phase.
    always @(posedge in_clk or posedge in_rst) begin
        if (in_rst)                        slave_addr <= 32'h0;
        else if (in_hready && out_htrans[1]) slave_addr <= out_haddr;
    end
    assign in_hrdata = slave_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_bus(input string tag, input logic [31:0] addr, input logic [1:0] trans);
        check_eq({tag, "_htrans"}, {30'h0, out_htrans}, {30'h0, trans});
        check_eq({tag, "_haddr"}, out_haddr, addr);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input logic err);
        check_eq({tag, "_valid"}, {31'h0, out_inst_valid}, 32'h1);
        check_eq({tag, "_pc"}, out_inst_pc, pc);
        check_eq({tag, "_inst"}, out_inst, inst);
        check_eq({tag, "_err"}, {31'h0, out_inst_err}, {31'h0, err});
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        in_init_done = 1'b0;
        in_hready = 1'b1;
        in_hresp = 1'b0;
        in_inst_ready = 1'b1;
        in_pc_override = 1'b0;
        in_pc_write = 32'h0;
        tick();
        tick();
        in_rst = 1'b0;
    endtask

    initial begin
        // Start-up and reset values
        do_reset();
        in_rst = 1'b1;
        tick();
        check_eq("rst_haddr", out_haddr, 32'h100);
        check_eq("rst_htrans", {30'h0, out_htrans}, 32'h0);
        check_eq("rst_valid", {31'h0, out_inst_valid}, 32'h0);
        check_eq("rst_inst", out_inst, 32'h0);
        check_eq("rst_pc", out_inst_pc, 32'h0);
        check_eq("rst_err", {31'h0, out_inst_err}, 32'h0);
        check_eq("rst_level", {29'h0, out_fifo_level}, 32'h0);
        check_eq("const_ctrl", {20'h0, out_hwrite, out_hsize, out_hburst, out_hprot, out_hmastlock},
                 {20'h0, 1'b0, 3'b010, 3'b001, 4'b0010, 1'b0});
        in_rst = 1'b0;
        tick();
        check_eq("no_init_idle", {30'h0, out_htrans}, 32'h0);
        in_init_done = 1'b1;
        tick();
        check_bus("su_c1", 32'h100, NSEQ);
        in_init_done = 1'b0;                  // falling after start: no effect
        tick();
        check_bus("su_c2", 32'h104, SEQ);
        tick();
        check_bus("su_c3", 32'h108, SEQ);
        check_head("su_c3", 32'h100, 32'h100, 1'b0);
        tick();
        check_bus("su_c4", 32'h10C, SEQ);
        check_head("su_c4", 32'h104, 32'h104, 1'b0);

        // Backpressure
        do_reset();
        in_inst_ready = 1'b0;
        in_init_done = 1'b1;
        tick();
        check_bus("bp_c1", 32'h100, NSEQ);
        tick();
        tick();
        tick();
        check_bus("bp_c4", 32'h10C, SEQ);
        tick();
        check_eq("bp_c5_idle", {30'h0, out_htrans}, 32'h0);
        tick();
        check_eq("bp_c6_idle", {30'h0, out_htrans}, 32'h0);
        check_eq("bp_c6_level", {29'h0, out_fifo_level}, 32'h4);
        check_head("bp_c6", 32'h100, 32'h100, 1'b0);
        in_inst_ready = 1'b1;
        tick();
        check_bus("bp_c7", 32'h110, NSEQ);
        check_head("bp_c7", 32'h104, 32'h104, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_head("bp_seq", 32'h108 + 32'(4 * i), 32'h108 + 32'(4 * i), 1'b0);
        end

        // Wait states during the data phase of 0x104
        do_reset();
        in_init_done = 1'b1;
        tick();
        tick();
        tick();
        in_hready = 1'b0;
        check_bus("ws_c3", 32'h108, SEQ);
        check_head("ws_c3", 32'h100, 32'h100, 1'b0);
        tick();
        check_bus("ws_c4", 32'h108, SEQ);
        check_eq("ws_c4_valid", {31'h0, out_inst_valid}, 32'h0);
        tick();
        check_bus("ws_c5", 32'h108, SEQ);
        tick();
        in_hready = 1'b1;
        check_bus("ws_c6", 32'h108, SEQ);
        tick();
        check_head("ws_c7", 32'h104, 32'h104, 1'b0);
        tick();
        check_head("ws_c8", 32'h108, 32'h108, 1'b0);

        // Redirect while the 0x108 data phase is pending
        do_reset();
        in_init_done = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check_head("rd_c4", 32'h104, 32'h104, 1'b0);
        in_pc_override = 1'b1;
        in_pc_write = 32'h2003;
        tick();
        in_pc_override = 1'b0;
        check_eq("rd_c5_level", {29'h0, out_fifo_level}, 32'h0);
        check_bus("rd_c5", 32'h2000, NSEQ);
        tick();
        check_eq("rd_c6_valid", {31'h0, out_inst_valid}, 32'h0);
        check_bus("rd_c6", 32'h2004, SEQ);
        tick();
        check_head("rd_c7", 32'h2000, 32'h2000, 1'b0);
        tick();
        check_head("rd_c8", 32'h2004, 32'h2004, 1'b0);

        // Bus error on 0x108
        do_reset();
        in_inst_ready = 1'b0;
        in_init_done = 1'b1;
        tick();
        tick();
        tick();
        tick();
        in_hready = 1'b0;
        in_hresp = 1'b1;
        check_bus("be_c4", 32'h10C, SEQ);
        tick();
        in_hready = 1'b1;
        check_eq("be_c5_idle", {30'h0, out_htrans}, 32'h0);
        tick();
        in_hresp = 1'b0;
        check_eq("be_c6_idle", {30'h0, out_htrans}, 32'h0);
        check_eq("be_c6_level", {29'h0, out_fifo_level}, 32'h3);
        tick();
        check_eq("be_c7_idle", {30'h0, out_htrans}, 32'h0);
        check_head("be_c7", 32'h100, 32'h100, 1'b0);
        in_inst_ready = 1'b1;
        tick();
        check_head("be_c8", 32'h104, 32'h104, 1'b0);
        tick();
        check_head("be_c9", 32'h108, 32'h0, 1'b1);
        tick();
        check_eq("be_c10_valid", {31'h0, out_inst_valid}, 32'h0);
        check_eq("be_c10_idle", {30'h0, out_htrans}, 32'h0);
        in_pc_override = 1'b1;
        in_pc_write = 32'h400;
        tick();
        in_pc_override = 1'b0;
        check_bus("be_c11", 32'h400, NSEQ);
        tick();
        check_bus("be_c12", 32'h404, SEQ);
        tick();
        check_head("be_c13", 32'h400, 32'h400, 1'b0);

        // Async reset mid-stream, then restart and address wrap
        do_reset();
        in_inst_ready = 1'b0;
        in_init_done = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("ar_level3", {29'h0, out_fifo_level}, 32'h3);
        in_rst = 1'b1;
        in_init_done = 1'b0;
        #1;
        check_eq("ar_htrans", {30'h0, out_htrans}, 32'h0);
        check_eq("ar_haddr", out_haddr, 32'h100);
        check_eq("ar_valid", {31'h0, out_inst_valid}, 32'h0);
        check_eq("ar_level", {29'h0, out_fifo_level}, 32'h0);
        check_eq("ar_inst", out_inst, 32'h0);
        check_eq("ar_pc", out_inst_pc, 32'h0);
        tick();
        in_rst = 1'b0;
        tick();
        check_eq("ar_noinit1", {30'h0, out_htrans}, 32'h0);
        tick();
        check_eq("ar_noinit2", {30'h0, out_htrans}, 32'h0);
        in_init_done = 1'b1;
        in_inst_ready = 1'b1;
        tick();
        check_bus("ar_c1", 32'h100, NSEQ);
        in_pc_override = 1'b1;
        in_pc_write = 32'hFFFF_FFFA;
        tick();
        in_pc_override = 1'b0;
        check_bus("wr_c2", 32'hFFFF_FFF8, NSEQ);
        tick();
        check_bus("wr_c3", 32'hFFFF_FFFC, SEQ);
        check_eq("wr_c3_valid", {31'h0, out_inst_valid}, 32'h0);
        tick();
        check_bus("wr_c4", 32'h0, SEQ);
        check_head("wr_c4", 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0);
        tick();
        check_head("wr_c5", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        tick();
        check_head("wr_c6", 32'h0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
